// File: rtl/sinegen_sched.sv
// -----------------------------------------------------------------------------
// sinegen_sched
//   Two-channel sine-generator scheduler. One synchronous single-port sine ROM
//   is shared between two phase accumulators. Reads alternate channel 0 then
//   channel 1, so each channel gets a new sample every second clock. Channel 1
//   adds a programmable address offset to its phase.
//
//   Optional feature macro: SINEGEN_SCHED_PHASE_SYNC_EN
//     When defined, adds input 'sync'. If sync=1 in RD1, both accumulators
//     load zero instead of advancing, so both channels restart phase-aligned.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   run enable
//   incr0     in   [ACC_WIDTH]      channel 0 phase increment per frame
//   incr1     in   [ACC_WIDTH]      channel 1 phase increment per frame
//   offset    in   [ADDRESS_WIDTH]  channel 1 address offset
//   sync      in   phase re-align (only with SINEGEN_SCHED_PHASE_SYNC_EN)
//   rom_addr  out  [ADDRESS_WIDTH]  registered ROM read address
//   rom_dout  in   [DATA_WIDTH]     ROM data, valid 1 cycle after rom_addr
//   dout0     out  [DATA_WIDTH]     channel 0 sample (held between updates)
//   dout1     out  [DATA_WIDTH]     channel 1 sample (held between updates)
//   valid0    out  one-cycle pulse when dout0 updates
//   valid1    out  one-cycle pulse when dout1 updates
// -----------------------------------------------------------------------------
module sinegen_sched #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [ACC_WIDTH-1:0]     incr0,
    input  logic [ACC_WIDTH-1:0]     incr1,
    input  logic [ADDRESS_WIDTH-1:0] offset,
`ifdef SINEGEN_SCHED_PHASE_SYNC_EN
    input  logic                     sync,
`endif
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_dout,
    output logic [DATA_WIDTH-1:0]    dout0,
    output logic [DATA_WIDTH-1:0]    dout1,
    output logic                     valid0,
    output logic                     valid1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2
    } state_t;

    state_t                   state_q,    state_d;
    logic [ACC_WIDTH-1:0]     acc0_q,     acc0_d;
    logic [ACC_WIDTH-1:0]     acc1_q,     acc1_d;
    logic [ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;

    // Issue tag pipeline: stage 1 lines up with the registered address,
    // stage 2 with the ROM's registered data.
    logic tag1_v_q,  tag1_v_d;
    logic tag1_ch_q, tag1_ch_d;
    logic tag2_v_q;
    logic tag2_ch_q;

    logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
    logic                  valid0_q, valid0_d;
    logic                  valid1_q, valid1_d;

    always_comb begin
        state_d    = state_q;
        acc0_d     = acc0_q;
        acc1_d     = acc1_q;
        rom_addr_d = rom_addr_q;
        tag1_v_d   = 1'b0;
        tag1_ch_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) state_d = RD0;
            end
            RD0: begin
                rom_addr_d = acc0_q[ACC_WIDTH-1 -: ADDRESS_WIDTH];
                tag1_v_d   = 1'b1;
                tag1_ch_d  = 1'b0;
                state_d    = RD1;
            end
            RD1: begin
                // Address uses acc1 before this frame's advance.
                rom_addr_d = acc1_q[ACC_WIDTH-1 -: ADDRESS_WIDTH] + offset;
                tag1_v_d   = 1'b1;
                tag1_ch_d  = 1'b1;
`ifdef SINEGEN_SCHED_PHASE_SYNC_EN
                if (sync) begin
                    acc0_d = '0;
                    acc1_d = '0;
                end else begin
                    acc0_d = acc0_q + incr0;
                    acc1_d = acc1_q + incr1;
                end
`else
                acc0_d = acc0_q + incr0;
                acc1_d = acc1_q + incr1;
`endif
                state_d = en ? RD0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample capture: the tag that reaches stage 2 matches the ROM data
    // presented on rom_dout this cycle.
    always_comb begin
        valid0_d = tag2_v_q && !tag2_ch_q;
        valid1_d = tag2_v_q &&  tag2_ch_q;
        dout0_d  = valid0_d ? rom_dout : dout0_q;
        dout1_d  = valid1_d ? rom_dout : dout1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc0_q     <= '0;
            acc1_q     <= '0;
            rom_addr_q <= '0;
            tag1_v_q   <= 1'b0;
            tag1_ch_q  <= 1'b0;
            tag2_v_q   <= 1'b0;
            tag2_ch_q  <= 1'b0;
            dout0_q    <= '0;
            dout1_q    <= '0;
            valid0_q   <= 1'b0;
            valid1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            rom_addr_q <= rom_addr_d;
            tag1_v_q   <= tag1_v_d;
            tag1_ch_q  <= tag1_ch_d;
            tag2_v_q   <= tag1_v_q;
            tag2_ch_q  <= tag1_ch_q;
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
            valid0_q   <= valid0_d;
            valid1_q   <= valid1_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign dout0    = dout0_q;
    assign dout1    = dout1_q;
    assign valid0   = valid0_q;
    assign valid1   = valid1_q;

endmodule

// File: tb/tb_sinegen_sched.sv
// -----------------------------------------------------------------------------
// tb_sinegen_sched
//   Directed bench for sinegen_sched with an identity ROM (mem[i] = i,
//   one-cycle registered). The script states, per clock edge, which read the
//   scheduler should issue; expected addresses come from the frame-level
//   accumulator arithmetic, and expected samples/valids follow two edges later.
//   Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sinegen_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] incr0;
    logic [15:0] incr1;
    logic [7:0]  offset;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_dout;
    logic [7:0]  dout0;
    logic [7:0]  dout1;
    logic        valid0;
    logic        valid1;
`ifdef SINEGEN_SCHED_PHASE_SYNC_EN
    logic        sync;
`endif

    sinegen_sched #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (8),
        .ACC_WIDTH     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .incr0    (incr0),
        .incr1    (incr1),
        .offset   (offset),
`ifdef SINEGEN_SCHED_PHASE_SYNC_EN
        .sync     (sync),
`endif
        .rom_addr (rom_addr),
        .rom_dout (rom_dout),
        .dout0    (dout0),
        .dout1    (dout1),
        .valid0   (valid0),
        .valid1   (valid1)
    );

    always #5 clk = ~clk;

    // Identity ROM, registered output
    always @(posedge clk) rom_dout <= rom_addr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Expected-read pipeline and expected outputs
    bit          p1_v, p1_ch, p2_v, p2_ch;
    logic [7:0]  p1_a, p2_a;
    logic [7:0]  e_addr, e_d0, e_d1;
    bit          e_v0, e_v1;
    logic [15:0] m_acc0, m_acc1;

    task automatic check_outputs(input string pfx);
        check({pfx, "rom_addr"}, 32'(rom_addr), 32'(e_addr));
        check({pfx, "valid0"},   32'(valid0),   32'(e_v0));
        check({pfx, "valid1"},   32'(valid1),   32'(e_v1));
        check({pfx, "dout0"},    32'(dout0),    32'(e_d0));
        check({pfx, "dout1"},    32'(dout1),    32'(e_d1));
    endtask

    // One clock edge; iss/ch/a describe the read expected to issue at it.
    task automatic cyc(input bit iss, input bit ch, input logic [7:0] a);
        @(negedge clk);
        e_v0 = p2_v && !p2_ch;
        e_v1 = p2_v &&  p2_ch;
        if (e_v0) e_d0 = p2_a;
        if (e_v1) e_d1 = p2_a;
        p2_v = p1_v; p2_ch = p1_ch; p2_a = p1_a;
        p1_v = iss;  p1_ch = ch;    p1_a = a;
        if (iss) e_addr = a;
        check_outputs("");
    endtask

    // One RD0+RD1 frame; en takes en_mid during RD1, do_sync pulses sync in RD1.
    task automatic frame(input bit en_mid, input bit do_sync);
        logic [7:0] a1;
        cyc(1'b1, 1'b0, m_acc0[15:8]);
        en = en_mid;
`ifdef SINEGEN_SCHED_PHASE_SYNC_EN
        sync = do_sync;
`endif
        a1 = m_acc1[15:8] + offset;
        cyc(1'b1, 1'b1, a1);
`ifdef SINEGEN_SCHED_PHASE_SYNC_EN
        sync = 1'b0;
`endif
        if (do_sync) begin
            m_acc0 = '0;
            m_acc1 = '0;
        end else begin
            m_acc0 = m_acc0 + incr0;
            m_acc1 = m_acc1 + incr1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        p1_v = 0; p1_ch = 0; p1_a = '0;
        p2_v = 0; p2_ch = 0; p2_a = '0;
        e_addr = '0; e_d0 = '0; e_d1 = '0; e_v0 = 0; e_v1 = 0;
        m_acc0 = '0; m_acc1 = '0;
        check_outputs("rst_");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; incr0 = '0; incr1 = '0; offset = '0;
`ifdef SINEGEN_SCHED_PHASE_SYNC_EN
        sync = 1'b0;
`endif
        do_reset();
        do_reset();

        // Continuous run, equal increments, no offset
        incr0 = 16'h0100; incr1 = 16'h0100; offset = 8'h00; en = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        repeat (8) frame(1'b1, 1'b0);

        // en dropped in RD0: RD1 still issues, two pulses drain, then idle
        en = 1'b0;
        frame(1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
        en = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        repeat (3) frame(1'b1, 1'b0);

        // en low in RD0 but back high during RD1: no idle bubble
        en = 1'b0;
        frame(1'b1, 1'b0);
        repeat (2) frame(1'b1, 1'b0);

        // Reset while in RD1 with two reads in flight; no pulses afterwards
        cyc(1'b1, 1'b0, m_acc0[15:8]);
        do_reset();
        repeat (3) cyc(1'b0, 1'b0, 8'h00);

        // Offset 128 through a full accumulator wrap (acc=0xFF00 -> 0x7F)
        offset = 8'd128; en = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        repeat (258) frame(1'b1, 1'b0);

        // Half-cycle channel 0, slow channel 1
        do_reset();
        incr0 = 16'h8000; incr1 = 16'h0040; offset = 8'h00; en = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        repeat (10) frame(1'b1, 1'b0);

`ifdef SINEGEN_SCHED_PHASE_SYNC_EN
        // Phase sync after 5 frames: next addresses are 0x00 and offset
        do_reset();
        incr0 = 16'h0100; incr1 = 16'h0100; offset = 8'h30; en = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        repeat (5) frame(1'b1, 1'b0);
        frame(1'b1, 1'b1);
        repeat (2) frame(1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sinegen_sched.md
Name: sinegen_sched

Overview:
- Two-channel sine-generator scheduler. Shares one synchronous single-port sine ROM between two phase accumulators.
- Time-multiplexes ROM reads, channel 0 then channel 1, to produce two sine streams at clk/2 sample rate.
- Channel 1 has a programmable phase offset.
- Sits between the top-level control inputs (enable, frequency increments, offset) and the sine ROM. Drives the ROM address and registers the returned samples per channel.

Parameters:
- ADDRESS_WIDTH, 8, ROM address width; ROM depth is 2**ADDRESS_WIDTH.
- DATA_WIDTH, 8, ROM sample width.
- ACC_WIDTH, 16, phase accumulator width. The top ADDRESS_WIDTH bits index the ROM. Must be >= ADDRESS_WIDTH.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- incr0  in  ACC_WIDTH  channel 0 phase increment per frame.
- incr1  in  ACC_WIDTH  channel 1 phase increment per frame.
- offset  in  ADDRESS_WIDTH  channel 1 address offset.
- rom_addr  out  ADDRESS_WIDTH  registered ROM read address.
- rom_dout  in  DATA_WIDTH  ROM data; registered in the ROM, valid 1 cycle after rom_addr.
- dout0  out  DATA_WIDTH  channel 0 sample.
- dout1  out  DATA_WIDTH  channel 1 sample.
- valid0  out  1  one-cycle pulse when dout0 updates.
- valid1  out  1  one-cycle pulse when dout1 updates.

Behaviour:
- One clock domain. Reset is synchronous and active-high: rst sampled high at a rising edge of clk resets the block.
- Reset values: state=IDLE, acc0=acc1=0, rom_addr=0, dout0=dout1=0, valid0=valid1=0, tag pipeline cleared.
- FSM states IDLE, RD0, RD1:
  - IDLE: if en=1, go to RD0; else stay.
  - RD0: register rom_addr=acc0[ACC_WIDTH-1 -: ADDRESS_WIDTH]; tag=ch0; go to RD1 unconditionally.
  - RD1: register rom_addr=(acc1 top bits + offset) mod 2**ADDRESS_WIDTH; tag=ch1. Update acc0+=incr0 and acc1+=incr1, both mod 2**ACC_WIDTH. Next state RD0 if en=1, else IDLE.
- A frame is RD0+RD1 (2 cycles). The accumulators advance exactly once per frame, at the RD1 edge.
- incr0, incr1 and offset are sampled only in the state that uses them; mid-frame changes take effect at the next use.
- Read pipeline: a 2-stage issue tag (valid bit + channel bit) tracks each read.
  - Edge k: rom_addr is registered.
  - Edge k+1: ROM registers its data.
  - Edge k+2: rom_dout is captured into dout0 or dout1 according to the tag, and the matching valid pulses high for the cycle after edge k+2.
  - Address-to-sample latency: 2 cycles.
- In continuous run, valid0 and valid1 alternate every cycle; each channel pulses every 2nd cycle.
- IDLE issues no reads. rom_addr holds its last value; tags are invalid.
- en deasserted mid-frame: the current frame always completes (RD1 issues). Reads in flight drain, producing their valid pulses. Then the block stays in IDLE with accumulators held.
- en reasserted in the same cycle RD1 completes: go straight to RD0, with no idle bubble.
- rst mid-operation: in-flight reads are discarded, no valid pulses follow, and all state returns to reset values on the next edge.
- Outputs dout0/dout1 hold their last sample between valid pulses.

Optional Feature:
- Macro SINEGEN_SCHED_PHASE_SYNC_EN.
- When defined: adds input port sync (1 bit). If sync=1 at the RD1 edge, acc0 and acc1 load 0 instead of incrementing. Both channels therefore restart phase-aligned at the next frame. sync is ignored in IDLE and RD0.
- When undefined: port sync is absent and the accumulators always increment.

Test Plan:
- ROM model mem[i]=i, 1-cycle registered. rst, then en=1, incr0=incr1=0x0100, offset=0 -> rom_addr 0,0,1,1,2,2,...; first valid0 2 cycles after the first RD0 issue; dout0 sequence 0,1,2,...; dout1 equal to dout0 one cycle later.
- Same as above with offset=128 -> each dout1 = (matching dout0 + 128) mod 256; at acc=0xFF00, dout1=0x7F.
- incr0=0x8000, incr1=0x0040 -> ch0 addresses alternate 0x00,0x80,0x00 (wrap); ch1 address increments by 1 every 4 frames.
- en dropped during RD0 -> RD1 still issued; exactly 2 further valid pulses (valid0 then valid1); then no pulses; acc values held; re-enable resumes from the held phase.
- rst asserted in RD1 with 2 reads in flight -> next cycle all outputs 0; no valid pulse for 3 cycles after reset while en=0.
- With SINEGEN_SCHED_PHASE_SYNC_EN: after 5 frames with incr0=0x0100, pulse sync during RD1 -> next ch0 and ch1 addresses are 0x00 and offset.
